// File: rtl/gb_timer_pkg.sv
// gb_timer_pkg: shared constants and types for the DIV/TIMA/TMA/TAC timer.
//   - register addresses on the 2-bit CPU bus
//   - TIMA sequencing FSM states
//   - system-counter bit chosen by each TAC[1:0] setting
//   - padding for the unused upper TAC bits on reads
package gb_timer_pkg;

    localparam logic [1:0] ADDR_DIV  = 2'd0;
    localparam logic [1:0] ADDR_TIMA = 2'd1;
    localparam logic [1:0] ADDR_TMA  = 2'd2;
    localparam logic [1:0] ADDR_TAC  = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DELAY = 1'b1
    } tima_state_e;

    // sys_cnt bit whose falling edge clocks TIMA, per TAC[1:0]
    localparam int unsigned TAC_SEL_BIT_0 = 9;  // 4096 Hz
    localparam int unsigned TAC_SEL_BIT_1 = 3;  // 262144 Hz
    localparam int unsigned TAC_SEL_BIT_2 = 5;  // 65536 Hz
    localparam int unsigned TAC_SEL_BIT_3 = 7;  // 16384 Hz

    localparam int unsigned OVF_DELAY_DEFAULT = 4;

    localparam logic [4:0] TAC_RD_PAD = 5'b11111;

endpackage

// File: rtl/gb_timer_cpu_clk_edge.sv
// cpu_clk_edge: turns the divider's cpu_clk level into a one-cycle tick
// in the clk domain. Usable by any peripheral fed from the divider.
//   clk     - fast system clock
//   rst     - synchronous active-high reset
//   cpu_clk - divided CPU clock level, synchronous to clk
//   tick    - high for the one clk cycle in which cpu_clk first reads high
module cpu_clk_edge (
    input  logic clk,
    input  logic rst,
    input  logic cpu_clk,
    output logic tick
);

    logic cpu_clk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_clk_q <= 1'b0;
        end else begin
            cpu_clk_q <= cpu_clk;
        end
    end

    assign tick = cpu_clk & ~cpu_clk_q;

endmodule

// File: rtl/gb_timer.sv
// gb_timer: DIV/TIMA/TMA/TAC timer block with timer interrupt request.
//   clk       - system clock
//   rst       - synchronous active-high reset
//   cpu_clk   - divided CPU clock level; each rising edge is one T-cycle
//   addr      - register select (DIV, TIMA, TMA, TAC)
//   wr_en     - one-cycle write strobe
//   wr_data   - write data
//   rd_data   - combinational read of the addressed register
//   irq_timer - one-clk interrupt pulse, coincident with the TIMA reload
//
// TIMA FSM
//   state    | meaning
//   ST_IDLE  | TIMA counts falling edges of the selected sys_cnt bit
//   ST_DELAY | TIMA overflowed and reads 00; waiting OVF_DELAY ticks to reload
module gb_timer
    import gb_timer_pkg::*;
#(
    parameter int unsigned TICK_SEL_0 = TAC_SEL_BIT_0,
    parameter int unsigned TICK_SEL_1 = TAC_SEL_BIT_1,
    parameter int unsigned TICK_SEL_2 = TAC_SEL_BIT_2,
    parameter int unsigned TICK_SEL_3 = TAC_SEL_BIT_3,
    parameter int unsigned OVF_DELAY  = OVF_DELAY_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_clk,
    input  logic [1:0] addr,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       irq_timer
);

    localparam int unsigned      DLY_W    = $clog2(OVF_DELAY + 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(OVF_DELAY - 1);

    logic             tick;
    logic [15:0]      sys_cnt;
    logic [7:0]       tima;
    logic [7:0]       tma;
    logic [2:0]       tac;
    logic             sel_bit;
    logic             t_in;
    logic             t_in_q;
    logic             t_fall;
    logic [DLY_W-1:0] dly_cnt;
    tima_state_e      state;
    tima_state_e      state_nxt;
    logic [7:0]       tima_nxt;
    logic [DLY_W-1:0] dly_nxt;
    logic             irq_nxt;
    logic             div_wr;
    logic             tima_wr;
    logic             tma_wr;
    logic             tac_wr;
    logic [7:0]       tma_eff;
    logic             reload;

    cpu_clk_edge u_edge (
        .clk     (clk),
        .rst     (rst),
        .cpu_clk (cpu_clk),
        .tick    (tick)
    );

    assign div_wr  = wr_en & (addr == ADDR_DIV);
    assign tima_wr = wr_en & (addr == ADDR_TIMA);
    assign tma_wr  = wr_en & (addr == ADDR_TMA);
    assign tac_wr  = wr_en & (addr == ADDR_TAC);

    // A TMA write lands in the same cycle as a reload, so the reload sees it.
    assign tma_eff = tma_wr ? wr_data : tma;

    always_comb begin
        sel_bit = 1'b0;
        case (tac[1:0])
            2'b00:   sel_bit = sys_cnt[TICK_SEL_0];
            2'b01:   sel_bit = sys_cnt[TICK_SEL_1];
            2'b10:   sel_bit = sys_cnt[TICK_SEL_2];
            default: sel_bit = sys_cnt[TICK_SEL_3];
        endcase
    end

    // Any change that drops t_in (counter roll, DIV clear, TAC rewrite) counts.
    assign t_in   = tac[2] & sel_bit;
    assign t_fall = t_in_q & ~t_in;

    assign reload = (state == ST_DELAY) & tick & (dly_cnt == DLY_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sys_cnt <= 16'h0000;
            t_in_q  <= 1'b0;
            tma     <= 8'h00;
            tac     <= 3'b000;
        end else begin
            if (div_wr) begin
                sys_cnt <= 16'h0000;
            end else if (tick) begin
                sys_cnt <= sys_cnt + 16'd1;
            end
            t_in_q <= t_in;
            if (tma_wr) begin
                tma <= wr_data;
            end
            if (tac_wr) begin
                tac <= wr_data[2:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!tima_wr && t_fall && (tima == 8'hFF)) begin
                    state_nxt = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (reload || tima_wr) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // In DELAY the reload outranks a TIMA write; before it, the write cancels.
    always_comb begin
        tima_nxt = tima;
        dly_nxt  = dly_cnt;
        irq_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                dly_nxt = '0;
                if (tima_wr) begin
                    tima_nxt = wr_data;
                end else if (t_fall) begin
                    tima_nxt = tima + 8'd1;
                end
            end
            ST_DELAY: begin
                if (reload) begin
                    tima_nxt = tma_eff;
                    irq_nxt  = 1'b1;
                end else begin
                    if (tima_wr) begin
                        tima_nxt = wr_data;
                    end
                    if (tick) begin
                        dly_nxt = dly_cnt + DLY_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tima      <= 8'h00;
            dly_cnt   <= '0;
            irq_timer <= 1'b0;
        end else begin
            tima      <= tima_nxt;
            dly_cnt   <= dly_nxt;
            irq_timer <= irq_nxt;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            ADDR_DIV:  rd_data = sys_cnt[15:8];
            ADDR_TIMA: rd_data = tima;
            ADDR_TMA:  rd_data = tma;
            default:   rd_data = {TAC_RD_PAD, tac};
        endcase
    end

endmodule

// File: tb/tb_gb_timer.sv
module tb_gb_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_clk;
    logic [1:0] addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       irq_timer;

    int checks   = 0;
    int failures = 0;
    int irq_seen = 0;

    always #5 clk = ~clk;

    gb_timer dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_clk   (cpu_clk),
        .addr      (addr),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .irq_timer (irq_timer)
    );

    // ---------------- reference model ----------------
    localparam int OVF = 4;
    int unsigned m_sys;
    bit          m_cq, m_tq, m_irq;
    logic [7:0]  m_tima, m_tma;
    logic [2:0]  m_tac;
    int          m_pend;   // ticks left until reload; 0 = no overflow pending

    function automatic int sel_of(logic [1:0] s);
        case (s)
            2'd0:    return 9;
            2'd1:    return 3;
            2'd2:    return 5;
            default: return 7;
        endcase
    endfunction

    function automatic logic [7:0] model_rd(logic [1:0] a);
        case (a)
            2'd0:    return m_sys[15:8];
            2'd1:    return m_tima;
            2'd2:    return m_tma;
            default: return {5'b11111, m_tac};
        endcase
    endfunction

    task automatic model_step(bit r, bit c, bit we, logic [1:0] a, logic [7:0] d);
        bit tick, tin, fall;
        logic [7:0] new_tma;
        if (r) begin
            m_sys = 0; m_cq = 0; m_tq = 0; m_irq = 0;
            m_tima = 0; m_tma = 0; m_tac = 0; m_pend = 0;
            return;
        end
        tick    = c && !m_cq;
        tin     = m_tac[2] && (((m_sys >> sel_of(m_tac[1:0])) & 1) == 1);
        fall    = m_tq && !tin;
        new_tma = (we && a == 2'd2) ? d : m_tma;
        m_irq   = 0;
        if (m_pend > 0) begin
            if (tick && m_pend == 1) begin
                m_tima = new_tma; m_irq = 1; m_pend = 0;
            end else if (we && a == 2'd1) begin
                m_tima = d; m_pend = 0;
            end else if (tick) begin
                m_pend--;
            end
        end else if (we && a == 2'd1) begin
            m_tima = d;
        end else if (fall) begin
            if (m_tima == 8'hFF) begin
                m_tima = 8'h00; m_pend = OVF;
            end else begin
                m_tima = m_tima + 8'd1;
            end
        end
        m_tma = new_tma;
        if (we && a == 2'd3) m_tac = d[2:0];
        if (we && a == 2'd0) m_sys = 0;
        else if (tick)       m_sys = (m_sys + 1) & 32'hFFFF;
        m_tq = tin;
        m_cq = c;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic do_cycle(bit r, bit c, bit we, logic [1:0] a, logic [7:0] d);
        rst = r; cpu_clk = c; wr_en = we; addr = a; wr_data = d;
        model_step(r, c, we, a, d);
        @(posedge clk);
        #1;
        if (irq_timer === 1'b1) irq_seen++;
        chk("model_rd", {8'h00, rd_data}, {8'h00, model_rd(a)});
        chk("model_irq", {15'h0, irq_timer}, {15'h0, m_irq});
    endtask

    task automatic tick_n(int n, logic [1:0] a);
        for (int i = 0; i < n; i++) begin
            do_cycle(0, 1, 0, a, 8'h00);
            do_cycle(0, 0, 0, a, 8'h00);
        end
    endtask

    task automatic wr(logic [1:0] a, logic [7:0] d);
        do_cycle(0, 0, 1, a, d);
    endtask

    task automatic rd(logic [1:0] a, output logic [7:0] v);
        do_cycle(0, 0, 0, a, 8'h00);
        v = rd_data;
    endtask

    task automatic do_reset();
        do_cycle(1, 0, 0, 2'd0, 8'h00);
        irq_seen = 0;
    endtask

    task automatic setup_overflow();
        logic [7:0] v;
        do_reset();
        wr(2'd2, 8'h80);
        wr(2'd1, 8'hFE);
        wr(2'd3, 8'h05);
        tick_n(32, 2'd1);
        rd(2'd1, v);
        chk("ovf_tima_zero", {8'h00, v}, 16'h0000);
    endtask

    typedef struct {
        bit         r;
        bit         we;
        logic [1:0] a;
        logic [7:0] d;
        logic [7:0] exp_rd;
        bit         exp_irq;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [7:0] v;
        logic [1:0] ra;
        logic [7:0] rdv;
        bit         rr, rc, rwe;

        vecs[0]  = '{1, 0, 2'd0, 8'h00, 8'h00, 0};
        vecs[1]  = '{0, 0, 2'd0, 8'h00, 8'h00, 0};
        vecs[2]  = '{0, 0, 2'd1, 8'h00, 8'h00, 0};
        vecs[3]  = '{0, 0, 2'd2, 8'h00, 8'h00, 0};
        vecs[4]  = '{0, 0, 2'd3, 8'h00, 8'hF8, 0};
        vecs[5]  = '{0, 1, 2'd2, 8'h5A, 8'h5A, 0};
        vecs[6]  = '{0, 1, 2'd3, 8'hF9, 8'hF9, 0};
        vecs[7]  = '{0, 1, 2'd3, 8'h02, 8'hFA, 0};
        vecs[8]  = '{0, 1, 2'd1, 8'h33, 8'h33, 0};
        vecs[9]  = '{0, 0, 2'd1, 8'h00, 8'h33, 0};
        vecs[10] = '{0, 1, 2'd0, 8'hAB, 8'h00, 0};
        vecs[11] = '{0, 0, 2'd2, 8'h00, 8'h5A, 0};

        for (int i = 0; i < 12; i++) begin
            do_cycle(vecs[i].r, 0, vecs[i].we, vecs[i].a, vecs[i].d);
            chk($sformatf("vec%0d_rd", i), {8'h00, rd_data}, {8'h00, vecs[i].exp_rd});
            chk($sformatf("vec%0d_irq", i), {15'h0, irq_timer}, {15'h0, vecs[i].exp_irq});
        end

        // DIV rate
        do_reset();
        tick_n(256, 2'd0);
        rd(2'd0, v); chk("div_rate_div", {8'h00, v}, 16'h0001);
        rd(2'd1, v); chk("div_rate_tima", {8'h00, v}, 16'h0000);
        chk("div_rate_irq", irq_seen[15:0], 16'd0);

        // Overflow and reload
        setup_overflow();
        irq_seen = 0;
        tick_n(3, 2'd1);
        rd(2'd1, v); chk("ovf_hold_tima", {8'h00, v}, 16'h0000);
        chk("ovf_hold_irq", irq_seen[15:0], 16'd0);
        tick_n(1, 2'd1);
        chk("ovf_irq_once", irq_seen[15:0], 16'd1);
        rd(2'd1, v); chk("ovf_reload_tima", {8'h00, v}, 16'h0080);

        // Cancel by TIMA write inside DELAY
        setup_overflow();
        irq_seen = 0;
        tick_n(2, 2'd1);
        wr(2'd1, 8'h42);
        tick_n(6, 2'd1);
        rd(2'd1, v); chk("cancel_tima", {8'h00, v}, 16'h0042);
        chk("cancel_irq", irq_seen[15:0], 16'd0);
        tick_n(8, 2'd1);
        rd(2'd1, v); chk("cancel_idle_inc", {8'h00, v}, 16'h0043);

        // TMA written in the reload cycle
        setup_overflow();
        irq_seen = 0;
        tick_n(3, 2'd1);
        do_cycle(0, 1, 1, 2'd2, 8'hC0);
        do_cycle(0, 0, 0, 2'd1, 8'h00);
        chk("tma_race_irq", irq_seen[15:0], 16'd1);
        rd(2'd1, v); chk("tma_race_tima", {8'h00, v}, 16'h00C0);

        // DIV-write falling-edge quirk
        do_reset();
        wr(2'd3, 8'h05);
        tick_n(8, 2'd0);
        wr(2'd1, 8'h10);
        wr(2'd0, 8'h00);
        chk("glitch_div", {8'h00, rd_data}, 16'h0000);
        rd(2'd1, v); chk("glitch_tima", {8'h00, v}, 16'h0011);

        // Reset in the middle of DELAY
        setup_overflow();
        tick_n(2, 2'd1);
        do_reset();
        rd(2'd0, v); chk("rst_div", {8'h00, v}, 16'h0000);
        rd(2'd1, v); chk("rst_tima", {8'h00, v}, 16'h0000);
        rd(2'd2, v); chk("rst_tma", {8'h00, v}, 16'h0000);
        rd(2'd3, v); chk("rst_tac", {8'h00, v}, 16'h00F8);
        tick_n(8, 2'd1);
        chk("rst_no_irq", irq_seen[15:0], 16'd0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rr  = ($urandom_range(0, 499) == 0);
            rc  = ($urandom_range(0, 1) == 1);
            rwe = ($urandom_range(0, 23) == 0);
            ra  = 2'($urandom_range(0, 3));
            rdv = 8'($urandom_range(0, 255));
            if (ra == 2'd1 && $urandom_range(0, 1) == 1) rdv = 8'hF8 | rdv[2:0] ;
            do_cycle(rr, rc, rwe, ra, rdv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
